// File: rtl/seg_scan_mux.sv
// ---------------------------------------------------------------------------
// seg_scan_mux
//   Drives a 4-digit multiplexed 7-segment display from four BCD digits.
//   A free-running divider steps one digit slot every SCAN_DIV clocks. The
//   first BLANK_CYC clocks of each slot turn every digit off, which keeps the
//   previous digit's segments from ghosting onto the next one. Digits and
//   decimal points are copied into a shadow register only once per frame, so
//   a single frame always shows one coherent value.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   digits   in   four BCD nibbles, [3:0] = digit 0 (rightmost)
//   dp_en    in   decimal-point enable per digit
//   blank_lz in   1 = blank leading zeros (sampled live, not shadowed)
//   Y        out  segment drive, Y[6:0] = g..a, Y[7] = dp (registered)
//   scan     out  one-hot digit enable, or all-off during blanking (registered)
// ---------------------------------------------------------------------------
module seg_scan_mux #(
   parameter int unsigned SCAN_DIV  = 10000,
   parameter int unsigned BLANK_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_en,
   input  logic        blank_lz,
   output logic [7:0]  Y,
   output logic [3:0]  scan
);

   localparam logic [15:0] CntMax   = 16'(SCAN_DIV - 1);
   localparam logic [15:0] BlankCnt = 16'(BLANK_CYC);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] sh_dig_q, sh_dig_d;
   logic [3:0]  sh_dp_q, sh_dp_d;
   logic        load_pend_q;
   logic [7:0]  y_q, y_d;
   logic [3:0]  scan_q, scan_d;

   logic        slot_end;
   logic        capture;
   logic [3:0]  nib;
   logic [6:0]  seg;
   logic        upper_zero;

   always_comb begin
      slot_end = (cnt_q == CntMax);
      cnt_d    = slot_end ? 16'd0 : cnt_q + 16'd1;
      idx_d    = slot_end ? idx_q + 2'd1 : idx_q;

      // Capture on the first clock after reset and on the last clock of a frame.
      capture  = load_pend_q | (slot_end & (idx_q == 2'd3));
      sh_dig_d = capture ? digits : sh_dig_q;
      sh_dp_d  = capture ? dp_en : sh_dp_q;

      nib = sh_dig_q[{idx_q, 2'b00} +: 4];

      unique case (nib)
         4'd0:    seg = 7'b0111111;
         4'd1:    seg = 7'b0000110;
         4'd2:    seg = 7'b1011011;
         4'd3:    seg = 7'b1001111;
         4'd4:    seg = 7'b1100110;
         4'd5:    seg = 7'b1101101;
         4'd6:    seg = 7'b1111101;
         4'd7:    seg = 7'b0000111;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1101111;
         default: seg = 7'b1000000;  // invalid BCD shows a dash
      endcase

      // This digit and all digits above it are zero; digit 0 never qualifies.
      // Invalid nibbles are nonzero, so they stop the blanking run.
      unique case (idx_q)
         2'd3:    upper_zero = (sh_dig_q[15:12] == 4'd0);
         2'd2:    upper_zero = (sh_dig_q[15:8] == 8'd0);
         2'd1:    upper_zero = (sh_dig_q[15:4] == 12'd0);
         default: upper_zero = 1'b0;
      endcase

      if (cnt_q < BlankCnt) begin
         scan_d = 4'b0000;
         y_d    = 8'h00;
      end else begin
         scan_d = 4'b0001 << idx_q;
         y_d    = {sh_dp_q[idx_q], (blank_lz & upper_zero) ? 7'b0000000 : seg};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= 16'd0;
         idx_q       <= 2'd0;
         sh_dig_q    <= 16'd0;
         sh_dp_q     <= 4'd0;
         load_pend_q <= 1'b1;
         y_q         <= 8'h00;
         scan_q      <= 4'b0001;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_dig_q    <= sh_dig_d;
         sh_dp_q     <= sh_dp_d;
         load_pend_q <= 1'b0;
         y_q         <= y_d;
         scan_q      <= scan_d;
      end
   end

   assign Y    = y_q;
   assign scan = scan_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

   localparam int unsigned SCAN_DIV  = 8;
   localparam int unsigned BLANK_CYC = 2;
   localparam int FRAME = 4 * SCAN_DIV;

   localparam logic [6:0] SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
   };

   logic        clk;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_en;
   logic        blank_lz;
   logic [7:0]  Y;
   logic [3:0]  scan;

   int checks;
   int failures;

   seg_scan_mux #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .digits   (digits),
      .dp_en    (dp_en),
      .blank_lz (blank_lz),
      .Y        (Y),
      .scan     (scan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: t is the number of clocks since reset release. The slot
   // and the position within it follow from plain division; the shadow is
   // re-sampled on the first clock and on the last clock of every frame.
   int          t;
   logic [15:0] m_dig;
   logic [3:0]  m_dp;
   logic [7:0]  exp_y;
   logic [3:0]  exp_scan;

   always @(posedge clk or posedge rst) begin
      int slot, pos;
      logic [15:0] above;
      logic [3:0]  nib;
      if (rst) begin
         t        = 0;
         m_dig    = 16'h0;
         m_dp     = 4'h0;
         exp_y    = 8'h00;
         exp_scan = 4'b0001;
      end else begin
         slot = (t / SCAN_DIV) % 4;
         pos  = t % SCAN_DIV;
         if (pos < BLANK_CYC) begin
            exp_scan = 4'b0000;
            exp_y    = 8'h00;
         end else begin
            nib      = m_dig[4*slot +: 4];
            above    = m_dig >> (4 * slot);
            exp_scan = 4'(1 << slot);
            exp_y    = {m_dp[slot], SEG[nib]};
            if (blank_lz && slot != 0 && above == 16'h0) exp_y[6:0] = 7'h00;
         end
         if (t == 0 || (t % FRAME) == FRAME - 1) begin
            m_dig = digits;
            m_dp  = dp_en;
         end
         t++;
      end
   end

   // scan must be either all-off or exactly one-hot on every cycle.
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(scan)) begin
         failures++;
         $display("FAIL scan_onehot0 scan=%b required zero or one-hot", scan);
      end
   end

   task automatic test_reset();
      rst      = 1'b1;
      digits   = 16'h1234;
      dp_en    = 4'h0;
      blank_lz = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (scan !== 4'b0001 || Y !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold scan=%b Y=%h required scan=0001 Y=00", scan, Y);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [7:0] want [4];
      want = '{8'h66, 8'h4F, 8'h5B, 8'h06};
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         checks++;
         if (Y !== exp_y || scan !== exp_scan) begin
            failures++;
            $display("FAIL basic_model c=%0d scan=%b Y=%h required scan=%b Y=%h",
                     c, scan, Y, exp_scan, exp_y);
         end
         // Each slot: two blank clocks then six clocks of the one-hot enable.
         checks++;
         if ((c % SCAN_DIV) < BLANK_CYC) begin
            if (scan !== 4'b0000 || Y !== 8'h00) begin
               failures++;
               $display("FAIL basic_blank c=%0d scan=%b Y=%h required 0000/00", c, scan, Y);
            end
         end else if (scan !== 4'(1 << ((c / SCAN_DIV) % 4)) ||
                      Y !== want[(c / SCAN_DIV) % 4]) begin
            failures++;
            $display("FAIL basic_slot c=%0d scan=%b Y=%h required scan=%b Y=%h", c, scan, Y,
                     4'(1 << ((c / SCAN_DIV) % 4)), want[(c / SCAN_DIV) % 4]);
         end
      end
   endtask

   // Drive one pattern, let it pass a frame wrap, then check every lit slot
   // against fixed per-digit values as well as against the model.
   task automatic test_pattern(input string name, input logic [15:0] d, input logic [3:0] dp,
                               input logic blz, input logic [31:0] want_packed);
      logic [7:0] want [4];
      for (int i = 0; i < 4; i++) want[i] = want_packed[8*i +: 8];
      digits   = d;
      dp_en    = dp;
      blank_lz = blz;
      for (int c = 0; c < FRAME + 8 + FRAME; c++) begin
         @(negedge clk);
         checks++;
         if (Y !== exp_y || scan !== exp_scan) begin
            failures++;
            $display("FAIL %s_model scan=%b Y=%h required scan=%b Y=%h",
                     name, scan, Y, exp_scan, exp_y);
         end
         if (c >= FRAME + 8) begin
            for (int i = 0; i < 4; i++) begin
               if (scan == 4'(1 << i)) begin
                  checks++;
                  if (Y !== want[i]) begin
                     failures++;
                     $display("FAIL %s_digit%0d Y=%h required %h", name, i, Y, want[i]);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_frame_coherence();
      int n;
      digits   = 16'h1111;
      dp_en    = 4'h0;
      blank_lz = 1'b0;
      repeat (FRAME + 8) @(negedge clk);
      n = 0;
      while (scan !== 4'b0010 && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (scan !== 4'b0010) begin
         failures++;
         $display("FAIL coherence_find_slot1 scan=%b required 0010", scan);
      end
      digits = 16'h2222;
      n = 0;
      while (scan !== 4'b0001 && n < 2 * FRAME) begin
         if (scan !== 4'b0000) begin
            checks++;
            if (Y !== 8'h06) begin
               failures++;
               $display("FAIL coherence_old_frame scan=%b Y=%h required 06", scan, Y);
            end
         end
         @(negedge clk);
         n++;
      end
      for (int c = 0; c < FRAME; c++) begin
         checks++;
         if (scan === 4'b0000 ? Y !== 8'h00 : Y !== 8'h5B) begin
            failures++;
            $display("FAIL coherence_new_frame scan=%b Y=%h required 5B when lit", scan, Y);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_slot();
      int n;
      logic [15:0] d;
      d        = 16'(($urandom % 9) + 1) | 16'h5670;
      dp_en    = 4'h0;
      blank_lz = 1'b0;
      n = 0;
      while (scan !== 4'b0100 && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      digits = d;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (scan !== 4'b0001 || Y !== 8'h00) begin
         failures++;
         $display("FAIL reset_async scan=%b Y=%h required 0001/00", scan, Y);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (scan !== 4'b0001 || Y !== 8'h00) begin
         failures++;
         $display("FAIL reset_held scan=%b Y=%h required 0001/00", scan, Y);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (c < 2 ? (scan !== 4'b0000 || Y !== 8'h00)
                   : (scan !== 4'b0001 || Y !== {1'b0, SEG[d[3:0]]})) begin
            failures++;
            $display("FAIL reset_restart c=%0d scan=%b Y=%h required %s", c, scan, Y,
                     c < 2 ? "blank" : "digit0 lit");
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 10 * FRAME; c++) begin
         if ($urandom_range(15) == 0) begin
            for (int i = 0; i < 4; i++)
               digits[4*i +: 4] = $urandom_range(1) ? 4'd0 : 4'($urandom_range(15));
            dp_en = 4'($urandom_range(15));
         end
         if ($urandom_range(31) == 0) blank_lz = ~blank_lz;
         @(negedge clk);
         checks++;
         if (Y !== exp_y || scan !== exp_scan) begin
            failures++;
            $display("FAIL random_model c=%0d scan=%b Y=%h required scan=%b Y=%h",
                     c, scan, Y, exp_scan, exp_y);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      digits   = 16'h0;
      dp_en    = 4'h0;
      blank_lz = 1'b0;
      test_reset();
      test_basic();
      // want_packed bytes: {digit3, digit2, digit1, digit0}
      test_pattern("lz_on",  16'h0007, 4'b0000, 1'b1, 32'h00_00_00_07);
      test_pattern("lz_off", 16'h0007, 4'b0000, 1'b0, 32'h3F_3F_3F_07);
      test_pattern("zero_dp", 16'h0000, 4'b0100, 1'b1, 32'h00_80_00_3F);
      test_pattern("dash",   16'h00A0, 4'b0000, 1'b1, 32'h00_00_40_3F);
      test_frame_coherence();
      test_reset_mid_slot();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
